// File: rtl/dual_clcg_gen.sv
// dual_clcg_gen
// Dual coupled-LCG pseudo-random bit generator. Two N-bit linear congruential
// recurrences X and Y advance in lock-step; each step emits z = (x > y) and
// shifts it into a W-bit word, presented MSB-first through a valid/ready
// handshake.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start, stop       begin generation (from IDLE) / abort back to IDLE
//   seed_x, seed_y    initial states loaded on start
//   a1, b1, a2, b2    multiplier/increment for X and Y (hold stable while busy)
//   word_ready        consumer accepts word_out
//   bit_out/bit_valid latest bit, one-cycle pulse per generated bit
//   word_out/word_valid packed word and its pending flag
//   busy              generator not in IDLE
//   cfg_err           loaded parameters do not give a full-period recurrence
module dual_clcg_gen #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] seed_x,
  input  logic [N-1:0] seed_y,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] a2,
  input  logic [N-1:0] b2,
  input  logic         word_ready,
  output logic         bit_out,
  output logic         bit_valid,
  output logic [W-1:0] word_out,
  output logic         word_valid,
  output logic         busy,
  output logic         cfg_err
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Full period of x' = a*x + b mod 2^N needs b odd and a = 1 mod 4.
  function automatic logic cfg_bad(input logic [N-1:0] ax, input logic [N-1:0] bx,
                                   input logic [N-1:0] ay, input logic [N-1:0] by);
    cfg_bad = ~bx[0] | ~by[0] | (ax[1:0] != 2'b01) | (ay[1:0] != 2'b01);
  endfunction

  state_t         state_q, state_d;
  logic [N-1:0]   x_q, x_d;
  logic [N-1:0]   y_q, y_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bit_out_q, bit_out_d;
  logic           bit_valid_q, bit_valid_d;
  logic [W-1:0]   word_out_q, word_out_d;
  logic           word_valid_q, word_valid_d;
  logic           busy_q, busy_d;
  logic           cfg_err_q, cfg_err_d;

  logic [N-1:0]   x_step;
  logic [N-1:0]   y_step;
  logic           z;
  logic [W-1:0]   shreg_step;
  logic           at_last;

  // Recurrence step values and the comparison bit from the current states.
  always_comb begin
    x_step     = a1 * x_q + b1;
    y_step     = a2 * y_q + b2;
    z          = (x_q > y_q);
    shreg_step = {shreg_q[W-2:0], z};
    at_last    = (cnt_q == CNT_LAST);
  end

  // Next-state and next-output logic for the IDLE/RUN/STALL controller.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    word_out_d   = word_out_q;
    // A pending word is retired by word_ready unless overwritten below.
    word_valid_d = word_valid_q & ~word_ready;
    cfg_err_d    = cfg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          x_d       = seed_x;
          y_d       = seed_y;
          cnt_d     = {CW{1'b0}};
          shreg_d   = {W{1'b0}};
          cfg_err_d = cfg_bad(a1, b1, a2, b2);
          state_d   = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          cnt_d   = {CW{1'b0}};
          shreg_d = {W{1'b0}};
          state_d = ST_IDLE;
        end else if (at_last && word_valid_q && !word_ready) begin
          // Completing step would overwrite an unconsumed word: hold off.
          state_d = ST_STALL;
        end else begin
          x_d         = x_step;
          y_d         = y_step;
          shreg_d     = shreg_step;
          bit_out_d   = z;
          bit_valid_d = 1'b1;
          if (at_last) begin
            word_out_d   = shreg_step;
            word_valid_d = 1'b1;
            cnt_d        = {CW{1'b0}};
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (stop) begin
          cnt_d   = {CW{1'b0}};
          shreg_d = {W{1'b0}};
          state_d = ST_IDLE;
        end else if (word_ready) begin
          // Pending word drains this cycle; the completing step runs next.
          state_d = ST_RUN;
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      x_q          <= {N{1'b0}};
      y_q          <= {N{1'b0}};
      shreg_q      <= {W{1'b0}};
      cnt_q        <= {CW{1'b0}};
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      word_out_q   <= {W{1'b0}};
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      word_out_q   <= word_out_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;

endmodule
